// File: rtl/guard_pred_match.sv
// Joins per-channel guard-condition FIFOs into one vector and matches it against masked patterns.
// The {idx,hit} result is forked to several consumers, each tracked with its own pending bit.
module guard_pred_match #(
   parameter int COND_WIDTH         = 2,
   parameter int NUM_PATTERNS       = 2,
   parameter logic [NUM_PATTERNS*COND_WIDTH-1:0] PATTERNS = {2'b00, 2'b11},
   parameter logic [NUM_PATTERNS*COND_WIDTH-1:0] MASKS    = '1,
   parameter int REPLICATED_OUT_NUM = 2,
   parameter int FIFO_SIZE          = 16,
   localparam int IDX_W             = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1,
   localparam int OUT_W             = 1 + IDX_W
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [COND_WIDTH-1:0]               s_guard_cond_tdata,
   input  logic [COND_WIDTH-1:0]               s_guard_cond_tvalid,
   output logic [COND_WIDTH-1:0]               s_guard_cond_tready,
   output logic [REPLICATED_OUT_NUM*OUT_W-1:0] m_guard_cond_tdata,
   output logic [REPLICATED_OUT_NUM-1:0]       m_guard_cond_tvalid,
   input  logic [REPLICATED_OUT_NUM-1:0]       m_guard_cond_tready,
   output logic [31:0]                         stat_eval_count,
   output logic [31:0]                         stat_hit_count
);

   localparam int AW = $clog2(FIFO_SIZE);

   // Lowest matching pattern wins; a miss reports idx 0.
   function automatic logic [OUT_W-1:0] match_vec(input logic [COND_WIDTH-1:0] v);
      logic [IDX_W-1:0] idx;
      logic             hit;
      logic             m;
      idx = '0;
      hit = 1'b0;
      for (int p = 0; p < NUM_PATTERNS; p++) begin
         m   = ((v ^ PATTERNS[p*COND_WIDTH +: COND_WIDTH]) & MASKS[p*COND_WIDTH +: COND_WIDTH]) == '0;
         idx = (m && !hit) ? IDX_W'(p) : idx;
         hit = hit | m;
      end
      return {idx, hit};
   endfunction

   logic [FIFO_SIZE-1:0]          mem_q    [COND_WIDTH];
   logic [FIFO_SIZE-1:0]          mem_d    [COND_WIDTH];
   logic [AW:0]                   wr_ptr_q [COND_WIDTH];
   logic [AW:0]                   wr_ptr_d [COND_WIDTH];
   logic [AW:0]                   rd_ptr_q [COND_WIDTH];
   logic [AW:0]                   rd_ptr_d [COND_WIDTH];
   logic [COND_WIDTH-1:0]         full_s;
   logic [COND_WIDTH-1:0]         empty_s;
   logic [COND_WIDTH-1:0]         push_s;
   logic [COND_WIDTH-1:0]         vec_s;
   logic                          join_valid_s;
   logic                          stage_free_s;
   logic                          load_s;
   logic [OUT_W-1:0]              match_s;
   logic [OUT_W-1:0]              data_q;
   logic [OUT_W-1:0]              data_d;
   logic [REPLICATED_OUT_NUM-1:0] pend_q;
   logic [REPLICATED_OUT_NUM-1:0] pend_d;
   logic [31:0]                   eval_q;
   logic [31:0]                   eval_d;
   logic [31:0]                   hits_q;
   logic [31:0]                   hits_d;

   // FIFO status, head bits and input handshakes
   always_comb begin
      for (int c = 0; c < COND_WIDTH; c++) begin
         full_s[c]  = (wr_ptr_q[c][AW] != rd_ptr_q[c][AW]) &&
                      (wr_ptr_q[c][AW-1:0] == rd_ptr_q[c][AW-1:0]);
         empty_s[c] = (wr_ptr_q[c] == rd_ptr_q[c]);
         vec_s[c]   = mem_q[c][rd_ptr_q[c][AW-1:0]];
         s_guard_cond_tready[c] = !rst && !full_s[c];
         push_s[c]  = s_guard_cond_tvalid[c] && s_guard_cond_tready[c];
      end
   end

   assign join_valid_s = &(~empty_s);
   // A replica that is still pending and not accepting this cycle blocks the next load.
   assign stage_free_s = (pend_q & ~m_guard_cond_tready) == '0;
   assign load_s       = join_valid_s && stage_free_s;
   assign match_s      = match_vec(vec_s);

   // Next-state for FIFOs, output stage and statistics
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      for (int c = 0; c < COND_WIDTH; c++) begin
         mem_d[c][wr_ptr_q[c][AW-1:0]] = push_s[c] ? s_guard_cond_tdata[c]
                                                   : mem_q[c][wr_ptr_q[c][AW-1:0]];
         wr_ptr_d[c] = push_s[c] ? wr_ptr_q[c] + (AW+1)'(1) : wr_ptr_q[c];
         rd_ptr_d[c] = load_s    ? rd_ptr_q[c] + (AW+1)'(1) : rd_ptr_q[c];
      end
      pend_d = load_s ? '1 : (pend_q & ~m_guard_cond_tready);
      data_d = load_s ? match_s : data_q;
      eval_d = load_s ? eval_q + 32'd1 : eval_q;
      hits_d = (load_s && match_s[0]) ? hits_q + 32'd1 : hits_q;
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int c = 0; c < COND_WIDTH; c++) begin
            mem_q[c]    <= '0;
            wr_ptr_q[c] <= '0;
            rd_ptr_q[c] <= '0;
         end
         data_q <= '0;
         pend_q <= '0;
         eval_q <= 32'd0;
         hits_q <= 32'd0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         data_q   <= data_d;
         pend_q   <= pend_d;
         eval_q   <= eval_d;
         hits_q   <= hits_d;
      end
   end

   assign m_guard_cond_tvalid = pend_q;
   assign m_guard_cond_tdata  = {REPLICATED_OUT_NUM{data_q}};
   assign stat_eval_count     = eval_q;
   assign stat_hit_count      = hits_q;

endmodule
